// File: rtl/lc3_fetch.sv
// LC-3 instruction-fetch stage: owns the program counter and the instruction-memory
// address, and resolves the next fetch address from the instruction that just completed.
module lc3_fetch (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_start,
  input  logic [3:0]  opCode_in,
  input  logic [8:0]  offset_in,
  input  logic [15:0] reg_in,
  input  logic [2:0]  br_nzp,
  input  logic [2:0]  result_nzp,
  output logic [15:0] addr_out,
  output logic        wea_out,
  output logic [15:0] pc
);

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_JSR  = 4'b0100;
  localparam logic [3:0] OP_RTI  = 4'b1000;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  logic        [15:0] pc_q;
  logic        [15:0] pc_d;
  logic        [15:0] addr_q;
  logic               started_q;
  logic        [15:0] pc_inc;
  logic        [15:0] br_tgt;
  logic signed [15:0] br_off;
  logic               br_taken;

  function automatic logic signed [15:0] sext9(input logic [8:0] v);
    return {{7{v[8]}}, v};
  endfunction

  // Branch target is relative to the incremented PC; all sums wrap modulo 2^16.
  assign br_off   = sext9(offset_in);
  assign pc_inc   = pc_q + 16'd1;
  assign br_tgt   = pc_inc + $unsigned(br_off);
  assign br_taken = |(br_nzp & result_nzp);

  always_comb begin
    pc_d = pc_inc;
    if (!started_q) begin
      pc_d = 16'h0000;
    end else begin
      unique case (opCode_in)
        OP_BR:                         pc_d = br_taken ? br_tgt : pc_inc;
        OP_JMP, OP_JSR, OP_TRAP, OP_RTI: pc_d = reg_in;
        default:                       pc_d = pc_inc;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= 16'h0000;
      addr_q    <= 16'h0000;
      started_q <= 1'b0;
    end else if (fetch_start) begin
      pc_q      <= pc_d;
      addr_q    <= pc_d;
      started_q <= 1'b1;
    end
  end

  assign pc       = pc_q;
  assign addr_out = addr_q;
  assign wea_out  = 1'b0;

endmodule

// File: tb/tb_lc3_fetch.sv
// Bench for lc3_fetch: directed and random fetches scored against a next-PC model.
module tb_lc3_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_start = 1'b0;
  logic [3:0]  opCode_in = 4'h0;
  logic [8:0]  offset_in = 9'h0;
  logic [15:0] reg_in = 16'h0;
  logic [2:0]  br_nzp = 3'h0;
  logic [2:0]  result_nzp = 3'h0;
  logic [15:0] addr_out;
  logic        wea_out;
  logic [15:0] pc;

  int checks = 0;
  int passes = 0;
  logic [15:0] exp_q[$];
  int mpc = 0;
  bit started = 1'b0;

  lc3_fetch dut (
    .clk(clk), .rst_n(rst_n), .fetch_start(fetch_start), .opCode_in(opCode_in),
    .offset_in(offset_in), .reg_in(reg_in), .br_nzp(br_nzp), .result_nzp(result_nzp),
    .addr_out(addr_out), .wea_out(wea_out), .pc(pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic int wrap16(input int x);
    return ((x % 65536) + 65536) % 65536;
  endfunction

  // Reference: next PC from the ISA rules, in plain integer arithmetic.
  function automatic int model_next(input int op, input int off, input int r,
                                    input int b, input int res);
    int soff;
    if (!started) return 0;
    if (op == 0) begin
      soff = (off >= 256) ? off - 512 : off;
      if ((b & res) != 0) return wrap16(mpc + 1 + soff);
      return wrap16(mpc + 1);
    end
    if (op == 12 || op == 4 || op == 15 || op == 8) return r;
    return wrap16(mpc + 1);
  endfunction

  task automatic scramble();
    opCode_in  = 4'($urandom_range(0, 15));
    offset_in  = 9'($urandom_range(0, 511));
    reg_in     = 16'($urandom_range(0, 65535));
    br_nzp     = 3'($urandom_range(0, 7));
    result_nzp = 3'($urandom_range(0, 7));
  endtask

  task automatic fetch(input logic [3:0] op, input logic [8:0] off, input logic [15:0] r,
                       input logic [2:0] b, input logic [2:0] res);
    int e;
    opCode_in = op; offset_in = off; reg_in = r; br_nzp = b; result_nzp = res;
    fetch_start = 1'b1;
    e = model_next(int'(op), int'(off), int'(r), int'(b), int'(res));
    started = 1'b1;
    mpc = e;
    exp_q.push_back(16'(e));
    @(posedge clk);
    #1;
    fetch_start = 1'b0;
    scramble();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      scramble();
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: pops one expectation per fetch edge, otherwise expects the last value held.
  initial begin
    logic        fired;
    logic [15:0] cur;
    logic [15:0] e;
    cur = 16'h0000;
    forever begin
      @(posedge clk);
      fired = fetch_start && rst_n;
      @(negedge clk);
      if (!rst_n) begin
        cur = 16'h0000;
        chk("reset_pc", pc, 16'h0000);
        chk("reset_addr", addr_out, 16'h0000);
        chk("reset_wea", {15'b0, wea_out}, 16'h0000);
      end else if (fired) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_fetch: pc %h with no expected entry", pc);
        end else begin
          e = exp_q.pop_front();
          cur = e;
          chk("fetch_pc", pc, e);
          chk("fetch_addr", addr_out, e);
          chk("fetch_wea", {15'b0, wea_out}, 16'h0000);
        end
      end else begin
        chk("hold_pc", pc, cur);
        chk("hold_addr", addr_out, cur);
      end
    end
  end

  initial begin
    int gap;
    logic [3:0] op;
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(3);

    // First fetch ignores its inputs; then two sequential steps.
    fetch(4'b1100, 9'h0, 16'hBEEF, 3'b111, 3'b111);
    fetch(4'b0001, 9'h0, 16'h0000, 3'b000, 3'b000);
    fetch(4'b0001, 9'h0, 16'h0000, 3'b000, 3'b000);
    idle(2);

    // Branch back by 2 from 0x0010, taken and not taken.
    fetch(4'b1100, 9'h0, 16'h0010, 3'b000, 3'b000);
    fetch(4'b0000, 9'h1FE, 16'h0, 3'b010, 3'b010);
    fetch(4'b1100, 9'h0, 16'h0010, 3'b000, 3'b000);
    fetch(4'b0000, 9'h1FE, 16'h0, 3'b010, 3'b100);
    fetch(4'b0000, 9'h005, 16'h0, 3'b000, 3'b111);

    // Redirects.
    fetch(4'b1100, 9'h0, 16'h3000, 3'b000, 3'b000);
    fetch(4'b1100, 9'h0, 16'h4000, 3'b000, 3'b000);
    fetch(4'b1111, 9'h0, 16'h0200, 3'b000, 3'b000);
    fetch(4'b0100, 9'h0, 16'h7777, 3'b000, 3'b000);
    fetch(4'b1000, 9'h0, 16'h0123, 3'b000, 3'b000);

    // Wrap-around in both directions.
    fetch(4'b1100, 9'h0, 16'hFFFF, 3'b000, 3'b000);
    fetch(4'b0101, 9'h0, 16'h0000, 3'b000, 3'b000);
    fetch(4'b1100, 9'h0, 16'h0001, 3'b000, 3'b000);
    fetch(4'b0000, 9'h1FD, 16'h0, 3'b001, 3'b001);
    idle(1);

    // Asynchronous reset between edges while pc=0x1234.
    fetch(4'b1100, 9'h0, 16'h1234, 3'b000, 3'b000);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_reset_pc", pc, 16'h0000);
    chk("async_reset_addr", addr_out, 16'h0000);
    started = 1'b0;
    mpc = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);
    fetch(4'b0001, 9'h0, 16'h0000, 3'b000, 3'b000);
    fetch(4'b0001, 9'h0, 16'h0000, 3'b000, 3'b000);

    // Random traffic with gaps and back-to-back fetches.
    for (int i = 0; i < 400; i++) begin
      op = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
      fetch(op, 9'($urandom_range(0, 511)), 16'($urandom_range(0, 65535)),
            3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      gap = $urandom_range(0, 2);
      if (gap != 0) idle(gap);
    end

    idle(3);
    chk("queue_drained", 16'(exp_q.size()), 16'h0000);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
